// File: rtl/class_result_reader_pkg.sv
// Shared types and constants for the class result reader: FSM states,
// default sizing and the active-low seven-segment glyph table.
package class_result_reader_pkg;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_SCORE_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index 15 first; segments g..a in bits 6..0, a lit segment reads 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/class_result_reader_hex7seg_decode.sv
// Combinational hex digit to seven-segment lookup; compiled only when
// CLASS_HEX_DECODE_EN is defined, so the default build carries no decoder.
`ifdef CLASS_HEX_DECODE_EN
module hex7seg_decode
    import class_result_reader_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule
`endif

// File: rtl/class_result_reader.sv
// Captures a vector of signed class scores on a product_rdy rising edge and
// scans it one class per cycle for the arg-max. Optional hex display via
// CLASS_HEX_DECODE_EN.
module class_result_reader
    import class_result_reader_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int SCORE_W     = DEF_SCORE_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           product_rdy,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_in,
    output logic [3:0]                     class_idx,
    output logic signed [SCORE_W-1:0]      max_score,
    output logic                           result_valid,
    output logic                           busy,
    output logic [7:0]                     overrun_cnt,
    output logic [6:0]                     hex_seg
);

    localparam logic [3:0] LAST_PTR = 4'(NUM_CLASSES - 1);

    state_t                    state;
    logic                      prev_rdy;
    logic signed [SCORE_W-1:0] score_q [NUM_CLASSES];
    logic signed [SCORE_W-1:0] best;
    logic [3:0]                best_idx;
    logic [3:0]                ptr;
    logic                      rise;

    assign rise = product_rdy & ~prev_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev_rdy     <= 1'b0;
            best         <= '0;
            best_idx     <= '0;
            ptr          <= '0;
            class_idx    <= '0;
            max_score    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun_cnt  <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) score_q[i] <= '0;
        end else begin
            prev_rdy     <= product_rdy;
            result_valid <= 1'b0;
            // Edges that land while a scan or its hand-off is pending are dropped.
            if (rise && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            case (state)
                IDLE: if (rise) begin
                    for (int i = 0; i < NUM_CLASSES; i++)
                        score_q[i] <= scores_in[i*SCORE_W +: SCORE_W];
                    best     <= scores_in[0 +: SCORE_W];
                    best_idx <= '0;
                    ptr      <= 4'd1;
                    busy     <= 1'b1;
                    state    <= SCAN;
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties.
                    if (score_q[ptr] > best) begin
                        best     <= score_q[ptr];
                        best_idx <= ptr;
                    end
                    ptr <= ptr + 4'd1;
                    if (ptr == LAST_PTR) state <= DONE;
                end
                DONE: begin
                    class_idx    <= best_idx;
                    max_score    <= best;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLASS_HEX_DECODE_EN
    logic [6:0] seg_next;

    hex7seg_decode u_hex (
        .digit (class_idx),
        .seg   (seg_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hex_seg <= SEG_TABLE[0];
        else        hex_seg <= seg_next;
    end
`else
    assign hex_seg = 7'h7F;
`endif

endmodule

// File: tb/tb_class_result_reader.sv
// Directed bench for class_result_reader: table of score vectors plus
// hand-written overrun, reset and held-level sequences.
module tb_class_result_reader;

    localparam int N = 10;
    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           product_rdy;
    logic [N*W-1:0] scores_in;
    logic [3:0]     class_idx;
    logic [W-1:0]   max_score;
    logic           result_valid;
    logic           busy;
    logic [7:0]     overrun_cnt;
    logic [6:0]     hex_seg;

    int checks = 0;
    int errors = 0;

    class_result_reader #(.NUM_CLASSES(N), .SCORE_W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .product_rdy  (product_rdy),
        .scores_in    (scores_in),
        .class_idx    (class_idx),
        .max_score    (max_score),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .hex_seg      (hex_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] scores;
        logic [3:0]     idx;
        logic [31:0]    mx;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [N*W-1:0] pk(input int a0, a1, a2, a3, a4,
                                          a5, a6, a7, a8, a9);
        logic [N*W-1:0] r;
        r = {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
        return r;
    endfunction

    function automatic logic [6:0] exp_hex(input logic [3:0] d);
`ifdef CLASS_HEX_DECODE_EN
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
            4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
            4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
`else
        return 7'h7F;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture at edge T, then walk to T+10 and verify the single result pulse.
    task automatic run(input vec_t v, input string name);
        int early;
        scores_in   = v.scores;
        product_rdy = 1'b1;
        tick();
        product_rdy = 1'b0;
        chk({name, " busy_scan"}, 32'(busy), 32'd1);
        early = 0;
        for (int k = 1; k < N; k++) begin
            tick();
            if (result_valid) early++;
        end
        chk({name, " early_valid"}, 32'(early), 32'd0);
        tick();
        chk({name, " valid"}, 32'(result_valid), 32'd1);
        chk({name, " idx"}, 32'(class_idx), 32'(v.idx));
        chk({name, " max"}, max_score, v.mx);
        chk({name, " busy_done"}, 32'(busy), 32'd0);
        tick();
        chk({name, " valid_drop"}, 32'(result_valid), 32'd0);
        chk({name, " hex"}, 32'(hex_seg), 32'(exp_hex(v.idx)));
        chk({name, " idx_hold"}, 32'(class_idx), 32'(v.idx));
    endtask

    initial begin
        int pulses;
        vec_t hv;

        vecs[0] = '{pk(5, -3, 9, 9, 0, 1, 2, 3, 4, 8), 4'd2, 32'd9};
        vecs[1] = '{pk(-7, -7, -7, -7, -7, -7, -7, -7, -7, -7), 4'd0, -32'sd7};
        vecs[2] = '{pk(-5, -1, -9, -100, -2, -3, -4, -6, -8, 0), 4'd9, 32'd0};
        vecs[3] = '{pk(0, int'(32'h8000_0000), 1, 2, 3, 32'h7FFF_FFFF,
                       32'h7FFF_FFFF, -1, 4, 5), 4'd5, 32'h7FFF_FFFF};
        vecs[4] = '{pk(-10, 20, 30, 40, 50, 60, 70, 80, 90, 100), 4'd9, 32'd100};
        vecs[5] = '{pk(7, 7, 7, 7, 8, 7, 7, 7, 8, 7), 4'd4, 32'd8};

        rst_n       = 1'b0;
        product_rdy = 1'b0;
        scores_in   = '0;
        #12;
        chk("rst idx", 32'(class_idx), 32'd0);
        chk("rst max", max_score, 32'd0);
        chk("rst valid", 32'(result_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ovr", 32'(overrun_cnt), 32'd0);
        chk("rst hex", 32'(hex_seg), 32'(exp_hex(4'd0)));
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

        // Second edge 4 cycles after capture is dropped and counted.
        scores_in   = vecs[0].scores;
        product_rdy = 1'b1;
        tick();
        product_rdy = 1'b0;
        scores_in   = vecs[4].scores;
        tick(); tick(); tick();
        product_rdy = 1'b1;
        tick();
        product_rdy = 1'b0;
        pulses = 0;
        for (int k = 5; k < N; k++) begin
            tick();
            if (result_valid) pulses++;
        end
        chk("ovr early_valid", 32'(pulses), 32'd0);
        tick();
        chk("ovr valid", 32'(result_valid), 32'd1);
        chk("ovr idx", 32'(class_idx), 32'd2);
        chk("ovr max", max_score, 32'd9);
        chk("ovr cnt1", 32'(overrun_cnt), 32'd1);

        // Toggle every cycle: five dropped edges per 12-cycle capture window.
        scores_in = vecs[0].scores;
        for (int k = 0; k < 800; k++) begin
            product_rdy = ~product_rdy;
            tick();
        end
        product_rdy = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        chk("ovr sat", 32'(overrun_cnt), 32'd255);
        chk("ovr idle", 32'(busy), 32'd0);

        // Reset five cycles into SCAN.
        scores_in   = vecs[4].scores;
        product_rdy = 1'b1;
        tick();
        product_rdy = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst idx", 32'(class_idx), 32'd0);
        chk("midrst max", max_score, 32'd0);
        chk("midrst valid", 32'(result_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst ovr", 32'(overrun_cnt), 32'd0);
        chk("midrst hex", 32'(hex_seg), 32'(exp_hex(4'd0)));
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (result_valid) pulses++;
        end
        chk("midrst no_pulse", 32'(pulses), 32'd0);
        run(vecs[1], "post_rst");

        // Level already high at reset release, held 50 cycles, scores change at T+1.
        rst_n       = 1'b0;
        product_rdy = 1'b1;
        hv          = '{pk(1, 2, 3, 50, 4, 5, 6, 7, 8, 9), 4'd3, 32'd50};
        scores_in   = hv.scores;
        tick();
        rst_n = 1'b1;
        tick();
        chk("hold busy", 32'(busy), 32'd1);
        scores_in = pk(0, 0, 0, 0, 0, 0, 0, 99, 0, 0);
        pulses = 0;
        for (int k = 1; k < 50; k++) begin
            tick();
            if (result_valid) pulses++;
            if (k == N) begin
                chk("hold valid_t10", 32'(result_valid), 32'd1);
                chk("hold idx", 32'(class_idx), 32'(hv.idx));
                chk("hold max", max_score, hv.mx);
            end
        end
        chk("hold pulses", 32'(pulses), 32'd1);
        chk("hold ovr", 32'(overrun_cnt), 32'd0);
        product_rdy = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
